// File: rtl/sa_scan_chain_ctrl_pkg.sv
// sa_scan_pkg: shared state encoding and request mode constants for the scan chain controller
package sa_scan_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_RESP    = 2'd3
  } state_t;
  localparam logic MODE_LOAD    = 1'b0;
  localparam logic MODE_CAPTURE = 1'b1;
endpackage

// File: rtl/sa_scan_chain_ctrl_if.sv
// sa_scan_chain_ctrl_if: request/response handshake plus scan chain pins
interface sa_scan_chain_ctrl_if #(parameter int CHAIN_LEN = 32);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_mode;
  logic [CHAIN_LEN-1:0] req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_data;
  logic                 scan_en;
  logic                 scan_se;
  logic                 scan_si;
  logic                 scan_so;
  logic                 busy;
  modport master (
    output req_valid, req_mode, req_data, rsp_ready, scan_so,
    input  req_ready, rsp_valid, rsp_data, scan_en, scan_se, scan_si, busy
  );
  modport slave (
    input  req_valid, req_mode, req_data, rsp_ready, scan_so,
    output req_ready, rsp_valid, rsp_data, scan_en, scan_se, scan_si, busy
  );
endinterface

// File: rtl/sa_scan_chain_ctrl.sv
// sa_scan_chain_ctrl: optional capture then CHAIN_LEN shifts, loading req_data and unloading the old chain
module sa_scan_chain_ctrl
  import sa_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input logic              CP,
  input logic              RST,
  sa_scan_chain_ctrl_if.slave bus
);
  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [CHAIN_LEN-1:0] r_sr, w_sr;
  always_ff @(posedge CP) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_sr    <= w_sr;
    end
  end
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_sr   = r_sr;
    case (r_state)
      ST_IDLE: if (bus.req_valid) begin
        w_sr   = bus.req_data;
        w_cnt  = '0;
        w_next = (bus.req_mode == MODE_CAPTURE) ? ST_CAPTURE : ST_SHIFT;
      end
      ST_CAPTURE: w_next = ST_SHIFT;
      ST_SHIFT: begin
        w_sr   = {bus.scan_so, r_sr[CHAIN_LEN-1:1]};
        w_cnt  = (r_cnt == CNT_W'(CHAIN_LEN-1)) ? '0 : r_cnt + 1'b1;
        w_next = (r_cnt == CNT_W'(CHAIN_LEN-1)) ? ST_RESP : ST_SHIFT;
      end
      default: w_next = bus.rsp_ready ? ST_IDLE : ST_RESP;
    endcase
  end
  // every output is decoded from registered state only
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_data  = (r_state == ST_RESP) ? r_sr : '0;
  assign bus.scan_en   = (r_state == ST_CAPTURE) || (r_state == ST_SHIFT);
  assign bus.scan_se   = (r_state == ST_SHIFT);
  assign bus.scan_si   = (r_state == ST_SHIFT) && r_sr[0];
endmodule

// File: tb/tb_sa_scan_chain_ctrl.sv
// tb_sa_scan_chain_ctrl: directed bench with an 8-flop mux-scan chain model (ch[0] = tail, ch[7] = head)
module tb_sa_scan_chain_ctrl;
  import sa_scan_pkg::*;
  localparam int L = 8;
  logic         clk = 1'b0;
  logic         rst;
  logic         ch_load;
  logic [L-1:0] ch;
  logic [L-1:0] d_func;
  int           n_chk = 0;
  int           n_err = 0;
  int           n;
  sa_scan_chain_ctrl_if #(.CHAIN_LEN(L)) bus ();
  sa_scan_chain_ctrl #(.CHAIN_LEN(L)) dut (.CP(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (ch_load) ch <= 8'hA5;
    else if (bus.scan_en) ch <= bus.scan_se ? {bus.scan_si, ch[L-1:1]} : d_func;
  end
  assign bus.scan_so = ch[0];
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask
  initial begin
    rst = 1'b1; ch_load = 1'b1; d_func = 8'h96;
    bus.req_valid = 1'b0; bus.req_mode = MODE_LOAD; bus.req_data = '0; bus.rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_scan_en", 32'(bus.scan_en), 32'd0);
    chk("rst_scan_se", 32'(bus.scan_se), 32'd0);
    chk("rst_scan_si", 32'(bus.scan_si), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0; ch_load = 1'b0;
    tick();
    // LOAD 3C over preset A5
    bus.req_valid = 1'b1; bus.req_mode = MODE_LOAD; bus.req_data = 8'h3C;
    tick();
    bus.req_valid = 1'b0;
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_ready_low", 32'(bus.req_ready), 32'd0);
    chk("load_se", 32'(bus.scan_se), 32'd1);
    chk("load_en", 32'(bus.scan_en), 32'd1);
    wait_rsp(n);
    chk("load_latency", 32'(n), 32'd9);
    chk("load_rsp_data", 32'(bus.rsp_data), 32'hA5);
    chk("load_chain", 32'(ch), 32'h3C);
    chk("load_resp_en", 32'(bus.scan_en), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("load_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("load_done_ready", 32'(bus.req_ready), 32'd1);
    // CAPTURE with functional D = 96
    bus.req_valid = 1'b1; bus.req_mode = MODE_CAPTURE; bus.req_data = 8'h00;
    tick();
    bus.req_valid = 1'b0;
    chk("cap_en", 32'(bus.scan_en), 32'd1);
    chk("cap_se", 32'(bus.scan_se), 32'd0);
    tick();
    chk("cap_shift_se", 32'(bus.scan_se), 32'd1);
    wait_rsp(n);
    chk("cap_latency", 32'(n + 1), 32'd10);
    chk("cap_rsp_data", 32'(bus.rsp_data), 32'h96);
    chk("cap_chain", 32'(ch), 32'h00);
    // backpressure with a competing request
    bus.req_valid = 1'b1; bus.req_mode = MODE_LOAD; bus.req_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data), 32'h96);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    // back-to-back: rsp_ready and req_valid together in RESP
    bus.req_data = 8'h5A; bus.rsp_ready = 1'b1;
    chk("b2b_resp", 32'(bus.rsp_valid), 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    chk("b2b_idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
    wait_rsp(n);
    chk("b2b_latency", 32'(n), 32'd9);
    chk("b2b_rsp_data", 32'(bus.rsp_data), 32'h00);
    chk("b2b_chain", 32'(ch), 32'h5A);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    // reset during the 4th shift cycle
    bus.req_valid = 1'b1; bus.req_mode = MODE_LOAD; bus.req_data = 8'hC3;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_shifting", 32'(bus.scan_se), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_en", 32'(bus.scan_en), 32'd0);
    chk("rstmid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid_chain", 32'(ch), 32'h35);
    bus.req_valid = 1'b1; bus.req_data = 8'h0F;
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(n);
    chk("post_latency", 32'(n), 32'd9);
    chk("post_rsp_data", 32'(bus.rsp_data), 32'h35);
    chk("post_chain", 32'(ch), 32'h0F);
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_idle", 32'(bus.req_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
